// File: rtl/fetcher.sv
// Instruction fetch stage: one imem read per enabled pulse, next-PC register.
// Define FETCHER_PREFETCH_EN to add a 1-entry prefetch buffer for npc.
module fetcher #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 15
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              enabled,
    input  logic              redirect_en,
    input  logic [31:0]       redirect_pc,
    output logic              completed,
    output logic              busy,
    output logic [31:0]       pc,
    output logic [31:0]       instr_raw,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_valid,
    input  logic [31:0]       imem_rdata
);
    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT, S_DONE, S_PFW
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] npc_q, npc_d;
    logic [31:0] fpc_q, fpc_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] rtgt_q, rtgt_d;
    logic        comp_q, comp_d;
    logic        rpend_q, rpend_d;
    logic [31:0] rtgt;
    logic [31:0] seq_npc;

    assign rtgt = redirect_pc & 32'hFFFF_FFFC;
    // a redirect pulse in the completion cycle beats an older pending one
    assign seq_npc = redirect_en ? rtgt :
                     rpend_q     ? rtgt_q : fpc_q + 32'd4;

    assign busy      = (state_q == S_REQ) || (state_q == S_WAIT) ||
                       (state_q == S_PFW);
    assign completed = comp_q & ~enabled;
    assign pc        = pc_q;
    assign instr_raw = instr_q;

`ifdef FETCHER_PREFETCH_EN
    logic        pb_valid_q, pb_valid_d;
    logic [31:0] pb_pc_q, pb_pc_d;
    logic [31:0] pb_data_q, pb_data_d;
    logic        pf_out_q, pf_out_d;
    logic [31:0] pf_pc_q, pf_pc_d;
    logic        pf_stale_q, pf_stale_d;
    logic        pf_iss_q, pf_iss_d;
    logic        pf_rsp, pf_busy, pf_fresh, hit_v;
    logic [31:0] hit_pc, hit_data;

    assign pf_rsp   = pf_out_q & imem_valid;
    assign pf_busy  = pf_out_q & ~imem_valid;
    assign pf_fresh = pf_rsp & ~pf_stale_q;
    // a prefetch response arriving in the enabled cycle can hit directly
    assign hit_v    = pf_fresh | pb_valid_q;
    assign hit_pc   = pf_fresh ? pf_pc_q : pb_pc_q;
    assign hit_data = pf_fresh ? imem_rdata : pb_data_q;
`endif

    always_comb begin
        state_d   = state_q;
        npc_d     = npc_q;
        fpc_d     = fpc_q;
        pc_d      = pc_q;
        instr_d   = instr_q;
        comp_d    = comp_q;
        rpend_d   = rpend_q;
        rtgt_d    = rtgt_q;
        imem_req  = 1'b0;
        imem_addr = '0;
`ifdef FETCHER_PREFETCH_EN
        pb_valid_d = pb_valid_q;
        pb_pc_d    = pb_pc_q;
        pb_data_d  = pb_data_q;
        pf_out_d   = pf_out_q;
        pf_pc_d    = pf_pc_q;
        pf_stale_d = pf_stale_q;
        pf_iss_d   = pf_iss_q;
        if (pf_rsp) begin
            pf_out_d = 1'b0;
            if (!pf_stale_q) begin
                pb_valid_d = 1'b1;
                pb_pc_d    = pf_pc_q;
                pb_data_d  = imem_rdata;
            end
        end
        if (redirect_en) begin
            pb_valid_d = 1'b0;
            if (pf_busy) pf_stale_d = 1'b1;
        end
`endif
        if (redirect_en && busy) begin
            rpend_d = 1'b1;
            rtgt_d  = rtgt;
        end

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (enabled) begin
                    comp_d  = 1'b0;
                    rpend_d = 1'b0;
                    fpc_d   = redirect_en ? rtgt : npc_q;
                    state_d = S_REQ;
`ifdef FETCHER_PREFETCH_EN
                    pf_iss_d = 1'b0;
                    if (pf_busy) begin
                        state_d = S_PFW;
                    end else if (!redirect_en && hit_v &&
                                 hit_pc == npc_q) begin
                        pc_d       = npc_q;
                        instr_d    = hit_data;
                        comp_d     = 1'b1;
                        npc_d      = npc_q + 32'd4;
                        pb_valid_d = 1'b0;
                        state_d    = S_DONE;
                    end
`endif
                end else if (redirect_en) begin
                    npc_d = rtgt;
                end
`ifdef FETCHER_PREFETCH_EN
                else if (state_q == S_DONE && !pf_iss_q && !pf_out_q) begin
                    imem_req   = 1'b1;
                    imem_addr  = npc_q[ADDR_W+1:2];
                    pf_out_d   = 1'b1;
                    pf_pc_d    = npc_q;
                    pf_stale_d = 1'b0;
                    pf_iss_d   = 1'b1;
                end
`endif
            end
            S_REQ: begin
                imem_req  = 1'b1;
                imem_addr = fpc_q[ADDR_W+1:2];
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (imem_valid) begin
                    pc_d    = fpc_q;
                    instr_d = imem_rdata;
                    comp_d  = 1'b1;
                    npc_d   = seq_npc;
                    rpend_d = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_PFW: begin
`ifdef FETCHER_PREFETCH_EN
                if (pf_rsp) begin
                    if (!pf_stale_q && pf_pc_q == fpc_q) begin
                        pc_d       = fpc_q;
                        instr_d    = imem_rdata;
                        comp_d     = 1'b1;
                        npc_d      = seq_npc;
                        rpend_d    = 1'b0;
                        pb_valid_d = 1'b0;
                        state_d    = S_DONE;
                    end else begin
                        state_d = S_REQ;
                    end
                end
`else
                state_d = S_REQ;
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            npc_q   <= RESET_PC;
            fpc_q   <= RESET_PC;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            comp_q  <= 1'b0;
            rpend_q <= 1'b0;
            rtgt_q  <= '0;
        end else begin
            state_q <= state_d;
            npc_q   <= npc_d;
            fpc_q   <= fpc_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            comp_q  <= comp_d;
            rpend_q <= rpend_d;
            rtgt_q  <= rtgt_d;
        end
    end

`ifdef FETCHER_PREFETCH_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pb_valid_q <= 1'b0;
            pb_pc_q    <= '0;
            pb_data_q  <= '0;
            pf_out_q   <= 1'b0;
            pf_pc_q    <= '0;
            pf_stale_q <= 1'b0;
            pf_iss_q   <= 1'b0;
        end else begin
            pb_valid_q <= pb_valid_d;
            pb_pc_q    <= pb_pc_d;
            pb_data_q  <= pb_data_d;
            pf_out_q   <= pf_out_d;
            pf_pc_q    <= pf_pc_d;
            pf_stale_q <= pf_stale_d;
            pf_iss_q   <= pf_iss_d;
        end
    end
`endif

endmodule

// File: tb/tb_fetcher.sv
// Directed bench for fetcher with a variable-latency instruction memory model.
// Build with FETCHER_PREFETCH_EN defined to exercise the prefetch buffer path.
module tb_fetcher;
    localparam int ADDR_W = 15;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              enabled = 1'b0;
    logic              redirect_en = 1'b0;
    logic [31:0]       redirect_pc = '0;
    logic              completed;
    logic              busy;
    logic [31:0]       pc;
    logic [31:0]       instr_raw;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_valid = 1'b0;
    logic [31:0]       imem_rdata = '0;

    int checks = 0;
    int failures = 0;

    int                lat = 1;
    int                cnt = 0;
    logic              pend = 1'b0;
    logic [ADDR_W-1:0] paddr = '0;
    logic [ADDR_W-1:0] last_addr = '0;
    int                req_count = 0;

    fetcher #(.RESET_PC(32'h0000_0000), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rstn(rstn), .enabled(enabled),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .completed(completed), .busy(busy), .pc(pc),
        .instr_raw(instr_raw), .imem_req(imem_req),
        .imem_addr(imem_addr), .imem_valid(imem_valid),
        .imem_rdata(imem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [ADDR_W-1:0] a);
        return (a == '0) ? 32'h0000_0013 : (32'hA500_0000 | 32'(a));
    endfunction

    // Response 'lat' cycles after the request cycle.
    always @(posedge clk) begin
        imem_valid <= 1'b0;
        if (pend) begin
            if (cnt <= 1) begin
                imem_valid <= 1'b1;
                imem_rdata <= memf(paddr);
                pend       <= 1'b0;
            end else begin
                cnt <= cnt - 1;
            end
        end
        if (imem_req) begin
            req_count <= req_count + 1;
            last_addr <= imem_addr;
            if (lat <= 1) begin
                imem_valid <= 1'b1;
                imem_rdata <= memf(imem_addr);
            end else begin
                pend  <= 1'b1;
                cnt   <= lat - 1;
                paddr <= imem_addr;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_fetch(input string tag, input logic rd,
                            input logic [31:0] rdpc, input int inj_at,
                            input logic [31:0] inj_pc,
                            input logic [31:0] exp_pc, input int exp_cyc);
        int n;
        int rc0;
        logic [ADDR_W-1:0] ea;
        ea = exp_pc[ADDR_W+1:2];
        @(negedge clk);
        rc0 = req_count;
        enabled = 1'b1;
        redirect_en = rd;
        redirect_pc = rdpc;
        #1 chk({tag, ".cdrop"}, 32'(completed), 32'd0);
        @(negedge clk);
        enabled = 1'b0;
        redirect_en = (inj_at == 1);
        redirect_pc = inj_pc;
        n = 1;
        while (!completed && n < 40) begin
            @(negedge clk);
            n++;
            redirect_en = (n == inj_at);
            redirect_pc = inj_pc;
        end
        redirect_en = 1'b0;
        chk({tag, ".cycles"}, 32'(n), 32'(exp_cyc));
        chk({tag, ".pc"}, pc, exp_pc);
        chk({tag, ".instr"}, instr_raw, memf(ea));
        chk({tag, ".addr"}, 32'(last_addr), 32'(ea));
        chk({tag, ".busy"}, 32'(busy), 32'd0);
`ifndef FETCHER_PREFETCH_EN
        chk({tag, ".reqs"}, 32'(req_count - rc0), 32'd1);
`endif
    endtask

    task automatic do_reset;
        rstn = 1'b0;
        #1;
        chk("rst.completed", 32'(completed), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.pc", pc, 32'h0);
        chk("rst.instr", instr_raw, 32'h0);
        chk("rst.req", 32'(imem_req), 32'd0);
        chk("rst.addr", 32'(imem_addr), 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        int rc0;
        @(negedge clk);
        do_reset();
`ifdef FETCHER_PREFETCH_EN
        do_fetch("p1", 1'b0, 32'h0, -1, 32'h0, 32'h0000_0000, 3);
        do_fetch("p2hit", 1'b0, 32'h0, -1, 32'h0, 32'h0000_0004, 1);
        @(negedge clk);
        redirect_en = 1'b1;
        redirect_pc = 32'h0000_0040;
        @(negedge clk);
        redirect_en = 1'b0;
        do_fetch("p3", 1'b0, 32'h0, -1, 32'h0, 32'h0000_0040, 3);
`else
        do_fetch("t1", 1'b0, 32'h0, -1, 32'h0, 32'h0000_0000, 3);
        do_fetch("t2a", 1'b0, 32'h0, -1, 32'h0, 32'h0000_0004, 3);
        do_fetch("t2b", 1'b0, 32'h0, -1, 32'h0, 32'h0000_0008, 3);
        // redirect while the fetch at 0xC is waiting on memory
        lat = 3;
        do_fetch("t3", 1'b0, 32'h0, 2, 32'h0000_0100, 32'h0000_000C, 5);
        lat = 1;
        do_fetch("t3n", 1'b0, 32'h0, -1, 32'h0, 32'h0000_0100, 3);
        do_fetch("t4", 1'b1, 32'h0000_0203, -1, 32'h0, 32'h0000_0200, 3);
        do_fetch("t4n", 1'b0, 32'h0, -1, 32'h0, 32'h0000_0204, 3);
        // idle redirect to the top word, then sequential wrap to 0
        @(negedge clk);
        redirect_en = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        @(negedge clk);
        redirect_en = 1'b0;
        do_fetch("wrap0", 1'b0, 32'h0, -1, 32'h0, 32'hFFFF_FFFC, 3);
        do_fetch("wrap1", 1'b0, 32'h0, -1, 32'h0, 32'h0000_0000, 3);
        // slow memory, extra enabled while busy, reset mid-fetch
        lat = 5;
        @(negedge clk);
        rc0 = req_count;
        enabled = 1'b1;
        @(negedge clk);
        enabled = 1'b0;
        @(negedge clk);
        enabled = 1'b1;
        #1 chk("t5.busy_wait", 32'(busy), 32'd1);
        @(negedge clk);
        enabled = 1'b0;
        chk("t5.busy_hold", 32'(busy), 32'd1);
        rstn = 1'b0;
        #1;
        chk("t5.rst_busy", 32'(busy), 32'd0);
        chk("t5.rst_pc", pc, 32'h0);
        chk("t5.rst_instr", instr_raw, 32'h0);
        chk("t5.rst_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (7) @(negedge clk);
        chk("t5.late_comp", 32'(completed), 32'd0);
        chk("t5.late_busy", 32'(busy), 32'd0);
        chk("t5.late_instr", instr_raw, 32'h0);
        chk("t5.reqs", 32'(req_count - rc0), 32'd1);
        lat = 1;
        do_fetch("t5n", 1'b0, 32'h0, -1, 32'h0, 32'h0000_0000, 3);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
